// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl
//   Instruction/data memory controller for the CPU cores. Two independent
//   request/response ports each run their own IDLE/WAIT/RESP FSM in front of
//   a private on-chip array. A program-load port fills instruction memory.
//
// Parameters
//   DATA_W      word width (multiple of 8)
//   ADDR_W      byte-address width of both ports
//   IMEM_DEPTH  instruction memory words
//   DMEM_DEPTH  data memory words
//   LAT         cycles from acceptance to response, 1..15
//   NOP_WORD    word returned on a failed fetch
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   if_req/if_addr              fetch request and byte address
//   if_ready/if_valid           fetch can-accept / one-cycle response strobe
//   if_rdata/if_err             fetched word / error, held between responses
//   d_req/d_we/d_be/d_addr/d_wdata   load/store request
//   d_ready/d_valid             data can-accept / one-cycle response strobe
//   d_rdata/d_err               load data (0 for stores) / error, held
//   ld_we/ld_addr/ld_data       program-load write into imem (fetch idle only)
//
// Build option
//   MEM_MISALIGN_CHECK_EN  when defined, any address whose low byte-offset
//                          bits are non-zero is reported as an error and a
//                          store to it is suppressed.
module cpu_mem_ctrl #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       IMEM_DEPTH = 64,
  parameter int unsigned       DMEM_DEPTH = 64,
  parameter int unsigned       LAT        = 1,
  parameter logic [DATA_W-1:0] NOP_WORD   = 32'h00000013
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          if_req,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic                          if_ready,
  output logic                          if_valid,
  output logic [DATA_W-1:0]             if_rdata,
  output logic                          if_err,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [DATA_W/8-1:0]           d_be,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          d_ready,
  output logic                          d_valid,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          d_err,
  input  logic                          ld_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]             ld_data
);

  localparam int unsigned      BE_W     = DATA_W / 8;
  localparam int unsigned      OFFS     = $clog2(BE_W);
  localparam int unsigned      IW       = $clog2(IMEM_DEPTH);
  localparam int unsigned      DWI      = $clog2(DMEM_DEPTH);
  localparam logic [ADDR_W-1:0] IMEM_LIM = ADDR_W'(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] DMEM_LIM = ADDR_W'(DMEM_DEPTH);
  localparam logic [3:0]       LAT_M1   = 4'(LAT - 1);
`ifdef MEM_MISALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BE_W - 1);
`endif

  // S_RST keeps ready low for the first cycle after reset is released.
  typedef enum logic [1:0] {S_RST, S_IDLE, S_WAIT, S_RESP} port_state_e;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] lim);
    logic bad;
    bad = (a >> OFFS) >= lim;
`ifdef MEM_MISALIGN_CHECK_EN
    bad = bad | ((a & LOW_MASK) != '0);
`endif
    return bad;
  endfunction

  logic [DATA_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  // ---------------------------------------------------------------- fetch
  port_state_e   if_state, if_state_nx;
  logic [3:0]    if_cnt, if_cnt_nx;
  logic [IW-1:0] if_idx_q, if_idx_eff;
  logic          if_bad_q, if_bad_eff;
  logic          if_accept;

  assign if_ready  = (if_state == S_IDLE) || (if_state == S_RESP);
  assign if_valid  = (if_state == S_RESP);
  assign if_accept = if_req && if_ready;

  // With LAT==1 the acceptance edge is also the response edge, so the
  // response path uses the request being captured, not the stored one.
  always_comb begin
    if_idx_eff = if_idx_q;
    if_bad_eff = if_bad_q;
    if (if_accept) begin
      if_idx_eff = if_addr[OFFS +: IW];
      if_bad_eff = addr_bad(if_addr, IMEM_LIM);
    end
  end

  always_comb begin
    if_state_nx = if_state;
    if_cnt_nx   = if_cnt;
    unique case (if_state)
      S_RST:  if_state_nx = S_IDLE;
      S_WAIT: begin
        if (if_cnt == 4'd1) if_state_nx = S_RESP;
        else                if_cnt_nx   = if_cnt - 4'd1;
      end
      default: begin
        if (if_accept) begin
          if (LAT_M1 == '0) begin
            if_state_nx = S_RESP;
          end else begin
            if_state_nx = S_WAIT;
            if_cnt_nx   = LAT_M1;
          end
        end else begin
          if_state_nx = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_state <= S_RST;
      if_cnt   <= '0;
      if_idx_q <= '0;
      if_bad_q <= 1'b0;
      if_rdata <= '0;
      if_err   <= 1'b0;
    end else begin
      if_state <= if_state_nx;
      if_cnt   <= if_cnt_nx;
      if (if_accept) begin
        if_idx_q <= if_idx_eff;
        if_bad_q <= if_bad_eff;
      end
      if (if_state_nx == S_RESP) begin
        if_err   <= if_bad_eff;
        if_rdata <= if_bad_eff ? NOP_WORD : imem[if_idx_eff];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we && (if_state == S_IDLE)) imem[ld_addr] <= ld_data;
  end

  // ----------------------------------------------------------- load/store
  port_state_e    d_state, d_state_nx;
  logic [3:0]     d_cnt, d_cnt_nx;
  logic [DWI-1:0] d_idx_q, d_idx_eff;
  logic           d_bad_q, d_bad_eff;
  logic           d_we_q, d_we_eff;
  logic           d_accept;

  assign d_ready  = (d_state == S_IDLE) || (d_state == S_RESP);
  assign d_valid  = (d_state == S_RESP);
  assign d_accept = d_req && d_ready;

  always_comb begin
    d_idx_eff = d_idx_q;
    d_bad_eff = d_bad_q;
    d_we_eff  = d_we_q;
    if (d_accept) begin
      d_idx_eff = d_addr[OFFS +: DWI];
      d_bad_eff = addr_bad(d_addr, DMEM_LIM);
      d_we_eff  = d_we;
    end
  end

  always_comb begin
    d_state_nx = d_state;
    d_cnt_nx   = d_cnt;
    unique case (d_state)
      S_RST:  d_state_nx = S_IDLE;
      S_WAIT: begin
        if (d_cnt == 4'd1) d_state_nx = S_RESP;
        else               d_cnt_nx   = d_cnt - 4'd1;
      end
      default: begin
        if (d_accept) begin
          if (LAT_M1 == '0) begin
            d_state_nx = S_RESP;
          end else begin
            d_state_nx = S_WAIT;
            d_cnt_nx   = LAT_M1;
          end
        end else begin
          d_state_nx = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_state <= S_RST;
      d_cnt   <= '0;
      d_idx_q <= '0;
      d_bad_q <= 1'b0;
      d_we_q  <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else begin
      d_state <= d_state_nx;
      d_cnt   <= d_cnt_nx;
      if (d_accept) begin
        d_idx_q <= d_idx_eff;
        d_bad_q <= d_bad_eff;
        d_we_q  <= d_we_eff;
      end
      if (d_state_nx == S_RESP) begin
        d_err   <= d_bad_eff;
        d_rdata <= (d_bad_eff || d_we_eff) ? '0 : dmem[d_idx_eff];
      end
    end
  end

  // Stores commit at the acceptance edge, so a later load always sees them.
  always_ff @(posedge clk) begin
    if (d_accept && d_we && !d_bad_eff) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (d_be[i]) dmem[d_idx_eff][8*i +: 8] <= d_wdata[8*i +: 8];
      end
    end
  end

endmodule
